// File: rtl/ram_pkg.sv
// Shared types and defaults for the byte-streamed burst RAM controller.
// State encoding, byte-index width helper and default geometry live here.
package ram_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 6;
    localparam int DEFAULT_LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_COMMIT,
        RD_FETCH,
        RD_SEND
    } state_t;

    // A one-byte word still needs a 1-bit index register to keep widths legal.
    function automatic int idxWidth(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/ram_sp_array.sv
// Single-port synchronous RAM with registered read data and no reset.
// Kept as its own module so a hard macro can be dropped in its place.
module ram_sp_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read-first behaviour; the controller never reads and writes one address together.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst RAM controller: byte-serial command/write/read streams over a word-wide array.
// Define RAM_BURST_EN to honour cmd_len; otherwise every command moves exactly one word.
module ram_burst_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [7:0]        rd_data,
    output logic              busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = idxWidth(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  byteIdx_q, byteIdx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] ramRdata;
    logic              ramWe;
    logic              loadCmd;
    logic              wordDone;
    logic              lastWord;

`ifdef RAM_BURST_EN
    logic [LEN_W-1:0]  remain_q, remain_d;

    assign lastWord = (remain_q == '0);

    // Words left after the current one; the all-ones length simply counts down from the top.
    always_comb begin
        remain_d = remain_q;
        if (loadCmd) begin
            remain_d = cmd_len;
        end else if (wordDone && !lastWord) begin
            remain_d = remain_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain_q <= '0;
        end else begin
            remain_q <= remain_d;
        end
    end
`else
    logic unusedSink;

    assign lastWord   = 1'b1;
    assign unusedSink = ^{cmd_len, loadCmd, wordDone};
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        byteIdx_d = byteIdx_q;
        word_d    = word_q;
        ramWe     = 1'b0;
        loadCmd   = 1'b0;
        wordDone  = 1'b0;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    loadCmd   = 1'b1;
                    addr_d    = cmd_addr;
                    byteIdx_d = '0;
                    state_d   = cmd_we ? WR_COLLECT : RD_FETCH;
                end
            end
            WR_COLLECT: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (byteIdx_q == IDX_W'(b)) begin
                            word_d[b*8 +: 8] = wr_data;
                        end
                    end
                    if (byteIdx_q == LAST_IDX) begin
                        byteIdx_d = '0;
                        state_d   = WR_COMMIT;
                    end else begin
                        byteIdx_d = byteIdx_q + IDX_W'(1);
                    end
                end
            end
            WR_COMMIT: begin
                ramWe    = 1'b1;
                wordDone = 1'b1;
                addr_d   = addr_q + ADDR_W'(1);
                state_d  = lastWord ? IDLE : WR_COLLECT;
            end
            RD_FETCH: begin
                state_d = RD_SEND;
            end
            RD_SEND: begin
                rd_valid = 1'b1;
                for (int b = 0; b < BYTES; b++) begin
                    if (byteIdx_q == IDX_W'(b)) begin
                        rd_data = ramRdata[b*8 +: 8];
                    end
                end
                if (rd_ready) begin
                    if (byteIdx_q == LAST_IDX) begin
                        wordDone  = 1'b1;
                        byteIdx_d = '0;
                        addr_d    = addr_q + ADDR_W'(1);
                        state_d   = lastWord ? IDLE : RD_FETCH;
                    end else begin
                        byteIdx_d = byteIdx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset drops any half-assembled word; the array itself keeps its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            byteIdx_q <= '0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            byteIdx_q <= byteIdx_d;
            word_q    <= word_d;
        end
    end

    ram_sp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (ramWe),
        .addr_i  (addr_q),
        .wdata_i (word_q),
        .rdata_o (ramRdata)
    );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl against a word-array reference model.
// Honours RAM_BURST_EN the same way as the design (one word per command when undefined).
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [5:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       busy;

    int nVec  = 0;
    int nFail = 0;

    logic [15:0] model [64];
    logic [15:0] wrQ [$];

    always #5 clk = ~clk;

    ram_burst_ctrl #(
        .DATA_W (16),
        .ADDR_W (6),
        .LEN_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    // Guards against a design that never returns to idle.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    function automatic int burstWords(input logic [3:0] len);
`ifdef RAM_BURST_EN
        return int'(len) + 1;
`else
        return 1;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVec++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstCmdReady", 32'(cmd_ready), 32'd1);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstRdValid", 32'(rd_valid), 32'd0);
        checkOutput("rstWrReady", 32'(wr_ready), 32'd0);
        checkOutput("rstRdData", 32'(rd_data), 32'd0);
    endtask

    // Reset is raised between clock edges so the asynchronous path is what gets observed.
    task automatic midReset();
        @(posedge clk);
        #2;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        rd_ready  = 1'b0;
        #1;
        checkResetOutputs();
        tick();
        rst = 1'b0;
        tick();
        checkResetOutputs();
    endtask

    task automatic waitCmdReady(input string tag);
        int cnt = 0;
        while (!cmd_ready && cnt < 50) begin
            tick();
            cnt++;
        end
        checkOutput(tag, 32'(cmd_ready), 32'd1);
    endtask

    task automatic doWrite(input logic [5:0] addr, input logic [3:0] len);
        int nWords = burstWords(len);
        logic [15:0] w;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        waitCmdReady("wrCmdReady");
        tick();
        cmd_valid = 1'b0;
        checkOutput("wrBusy", 32'(busy), 32'd1);
        for (int n = 0; n < nWords; n++) begin
            w = wrQ[n];
            for (int b = 0; b < 2; b++) begin
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
                checkOutput("wrReady", 32'(wr_ready), 32'd1);
                wr_valid = 1'b1;
                wr_data  = w[8*b +: 8];
                tick();
                wr_valid = 1'b0;
            end
            checkOutput("wrCommitReady", 32'(wr_ready), 32'd0);
            checkOutput("wrCommitBusy", 32'(busy), 32'd1);
            tick();
            model[6'(int'(addr) + n)] = w;
        end
        checkOutput("wrEndIdle", 32'(cmd_ready), 32'd1);
        checkOutput("wrEndBusy", 32'(busy), 32'd0);
        wrQ.delete();
    endtask

    task automatic doRead(input logic [5:0] addr, input logic [3:0] len, input int stall);
        int nWords = burstWords(len);
        logic [15:0] w;
        logic [7:0]  expByte;
        int          st;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = addr;
        cmd_len   = len;
        waitCmdReady("rdCmdReady");
        tick();
        cmd_valid = 1'b0;
        checkOutput("rdFetchGap", 32'(rd_valid), 32'd0);
        tick();
        checkOutput("rdLatency", 32'(rd_valid), 32'd1);
        for (int n = 0; n < nWords; n++) begin
            if (n > 0) begin
                checkOutput("rdRefetchGap", 32'(rd_valid), 32'd0);
                tick();
            end
            w = model[6'(int'(addr) + n)];
            for (int b = 0; b < 2; b++) begin
                expByte = w[8*b +: 8];
                st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
                for (int s = 0; s < st; s++) begin
                    checkOutput("rdHoldValid", 32'(rd_valid), 32'd1);
                    checkOutput("rdHoldData", 32'(rd_data), 32'(expByte));
                    tick();
                end
                rd_ready = 1'b1;
                checkOutput("rdValid", 32'(rd_valid), 32'd1);
                checkOutput("rdData", 32'(rd_data), 32'(expByte));
                tick();
                rd_ready = 1'b0;
            end
        end
        checkOutput("rdEndIdle", 32'(cmd_ready), 32'd1);
        checkOutput("rdEndBusy", 32'(busy), 32'd0);
    endtask

    task automatic applyStimulus(input logic we, input logic [5:0] addr, input logic [3:0] len, input int stall);
        if (we) begin
            doWrite(addr, len);
        end else begin
            doRead(addr, len, stall);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        #12;
        checkResetOutputs();
        tick();
        rst = 1'b0;
        tick();
        checkResetOutputs();

        // Give every address a known value so later reads are fully predictable.
        for (int a = 0; a < 64; a += burstWords(4'hF)) begin
            for (int i = 0; i < 16; i++) wrQ.push_back(16'($urandom));
            applyStimulus(1'b1, 6'(a), 4'hF, 0);
        end

        // Reset while a read is presenting data.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 6'd0;
        cmd_len   = 4'd3;
        waitCmdReady("rstRdCmd");
        tick();
        cmd_valid = 1'b0;
        tick();
        checkOutput("rstRdValidBefore", 32'(rd_valid), 32'd1);
        midReset();

        // Single word at address 5.
        wrQ.push_back(16'h1234);
        applyStimulus(1'b1, 6'd5, 4'd0, 0);
        checkOutput("modelAddr5", 32'(model[5]), 32'h1234);
        applyStimulus(1'b0, 6'd5, 4'd0, 0);

        // Burst crossing the top of the array.
        wrQ.push_back(16'h1111);
        wrQ.push_back(16'h2222);
        wrQ.push_back(16'h3333);
        wrQ.push_back(16'h4444);
        applyStimulus(1'b1, 6'd62, 4'd3, 0);
        applyStimulus(1'b0, 6'd0, 4'd1, -1);
        applyStimulus(1'b0, 6'd62, 4'd3, -1);

        // Read backpressure of five cycles on every byte.
        applyStimulus(1'b0, 6'd5, 4'd0, 5);

        // Abandoned write at address 9 and a command offered while busy.
        wrQ.push_back(16'hBEEF);
        applyStimulus(1'b1, 6'd9, 4'd0, 0);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 6'd9;
        cmd_len   = 4'd0;
        waitCmdReady("abortCmd");
        tick();
        cmd_we   = 1'b0;
        cmd_addr = 6'd20;
        checkOutput("busyCmdReady", 32'(cmd_ready), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        tick();
        wr_valid = 1'b0;
        checkOutput("busyCmdReady2", 32'(cmd_ready), 32'd0);
        checkOutput("busyMidWord", 32'(busy), 32'd1);
        checkOutput("busyRdValid", 32'(rd_valid), 32'd0);
        midReset();
        applyStimulus(1'b0, 6'd9, 4'd0, 0);

        // Length field on a write starting at address 2; address 3 follows the model.
        wrQ.push_back(16'h3C3C);
        applyStimulus(1'b1, 6'd3, 4'd0, 0);
        for (int i = 0; i < 4; i++) wrQ.push_back(16'hA000 + 16'(i));
        applyStimulus(1'b1, 6'd2, 4'd3, 0);
        applyStimulus(1'b0, 6'd2, 4'd0, 0);
        applyStimulus(1'b0, 6'd3, 4'd0, 0);

        // Randomised mix of reads and writes, including the all-ones length.
        for (int t = 0; t < 30; t++) begin
            logic       we;
            logic [5:0] addr;
            logic [3:0] len;
            we   = 1'($urandom_range(0, 1));
            addr = 6'($urandom_range(0, 63));
            len  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            if (we) begin
                for (int i = 0; i <= int'(len); i++) wrQ.push_back(16'($urandom));
            end
            applyStimulus(we, addr, len, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
